// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between instruction fetch (i_*)
// and data access (d_*). Only one transaction is in flight at a time, and
// each one uses an address phase followed by a data phase.
//
// Ports:
//   clk, reset              rising-edge clock; asynchronous active-high reset
//   i_valid, i_addr         fetch request, held until i_addr_ok
//   i_addr_ok, i_data_ok    fetch address accepted / fetch data returned
//   i_data                  fetch read data (qualify with i_data_ok)
//   d_valid, d_addr         data request, held until d_addr_ok
//   d_strobe, d_wdata       byte enables (0 = read) and write data
//   d_addr_ok, d_data_ok    data address accepted / data transaction done
//   d_data                  data read data (qualify with d_data_ok)
//   m_valid, m_addr         shared memory request and address
//   m_strobe, m_wdata       shared byte enables (0 for fetch) and write data
//   m_addr_ok, m_data_ok    memory address accepted / transaction done
//   m_data                  memory read data
//   busy                    high whenever a grant is outstanding
//
// Data requests win arbitration. A fetch can only be passed over
// MAX_D_STREAK times in a row before it is granted.

module mem_bus_arbiter #(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        i_valid,
   input  logic [31:0] i_addr,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   output logic [31:0] i_data,

   input  logic        d_valid,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_strobe,
   input  logic [31:0] d_wdata,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic [31:0] d_data,

   output logic        m_valid,
   output logic [31:0] m_addr,
   output logic [3:0]  m_strobe,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_data,

   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      I_ADDR,
      I_DATA,
      D_ADDR,
      D_DATA
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   state_t     state;
   state_t     nextState;
   logic [3:0] streak;
   logic [3:0] nextStreak;
   logic       streakFull;
   logic [3:0] streakInc;

   // Streak counts data grants made while a fetch was waiting.
   // Once it reaches the limit, the pending fetch goes next.
   assign streakFull = (streak >= STREAK_MAX);
   assign streakInc  = streakFull ? streak : streak + 4'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         streak <= 4'd0;
      end else begin
         state  <= nextState;
         streak <= nextStreak;
      end
   end

   always_comb begin
      nextState  = state;
      nextStreak = streak;
      m_valid    = 1'b0;
      m_addr     = 32'h0;
      m_strobe   = 4'h0;
      m_wdata    = 32'h0;
      i_addr_ok  = 1'b0;
      i_data_ok  = 1'b0;
      d_addr_ok  = 1'b0;
      d_data_ok  = 1'b0;

      unique case (state)
         IDLE: begin
            // Memory responses are ignored while idle.
            if (d_valid && (!i_valid || !streakFull)) begin
               nextState  = D_ADDR;
               nextStreak = i_valid ? streakInc : 4'd0;
            end else if (i_valid) begin
               nextState  = I_ADDR;
               nextStreak = 4'd0;
            end
         end

         I_ADDR: begin
            m_valid   = 1'b1;
            m_addr    = i_addr;
            i_addr_ok = m_addr_ok;
            if (m_addr_ok) begin
               // A same-cycle data_ok completes the transfer at once.
               if (m_data_ok) begin
                  i_data_ok = 1'b1;
                  nextState = IDLE;
               end else begin
                  nextState = I_DATA;
               end
            end
         end

         I_DATA: begin
            i_data_ok = m_data_ok;
            if (m_data_ok) begin
               nextState = IDLE;
            end
         end

         D_ADDR: begin
            m_valid   = 1'b1;
            m_addr    = d_addr;
            m_strobe  = d_strobe;
            m_wdata   = d_wdata;
            d_addr_ok = m_addr_ok;
            if (m_addr_ok) begin
               if (m_data_ok) begin
                  d_data_ok = 1'b1;
                  nextState = IDLE;
               end else begin
                  nextState = D_DATA;
               end
            end
         end

         D_DATA: begin
            d_data_ok = m_data_ok;
            if (m_data_ok) begin
               nextState = IDLE;
            end
         end

         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Read data is shared; each requester qualifies it with its data_ok.
   assign i_data = m_data;
   assign d_data = m_data;
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter
// against a transaction-level reference model of the arbitration rules.

module tb_mem_bus_arbiter;

   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid;
   logic [31:0] i_addr;
   logic        i_addr_ok;
   logic        i_data_ok;
   logic [31:0] i_data;
   logic        d_valid;
   logic [31:0] d_addr;
   logic [3:0]  d_strobe;
   logic [31:0] d_wdata;
   logic        d_addr_ok;
   logic        d_data_ok;
   logic [31:0] d_data;
   logic        m_valid;
   logic [31:0] m_addr;
   logic [3:0]  m_strobe;
   logic [31:0] m_wdata;
   logic        m_addr_ok;
   logic        m_data_ok;
   logic [31:0] m_data;
   logic        busy;

   mem_bus_arbiter #(.MAX_D_STREAK(MAXS)) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_addr(i_addr),
      .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
      .d_valid(d_valid), .d_addr(d_addr), .d_strobe(d_strobe),
      .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
      .d_data(d_data),
      .m_valid(m_valid), .m_addr(m_addr), .m_strobe(m_strobe),
      .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
      .m_data(m_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Transaction-level model: ph 0 = no grant, 1 = address phase,
   // 2 = waiting for data. dRun counts data grants passing a waiting fetch.
   int          ph = 0;
   bit          ownD = 1'b0;
   int          dRun = 0;
   string       order = "";
   bit          iPend = 1'b0;
   bit          dPend = 1'b0;
   logic [31:0] iA = 32'h0;
   logic [31:0] dA = 32'h0;
   logic [31:0] dW = 32'h0;
   logic [3:0]  dS = 4'h0;
   logic [31:0] memData = 32'h0;

   int unsigned iProb = 0;
   int unsigned dProb = 0;
   int unsigned acceptPct = 100;
   int unsigned latMin = 1;
   int unsigned latMax = 1;
   bit          spur = 1'b0;
   int unsigned waitCnt = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkStr(input string tag, input string obs,
                         input string exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
      end
   endtask

   task automatic modelDecide();
      if (ph == 0) begin
         if (dPend && (!iPend || dRun < MAXS)) begin
            ownD = 1'b1;
            dRun = iPend ? dRun + 1 : 0;
            ph   = 1;
         end else if (iPend) begin
            ownD = 1'b0;
            dRun = 0;
            ph   = 1;
         end
      end
   endtask

   task automatic driveReq();
      i_valid  = iPend;
      i_addr   = iA;
      d_valid  = dPend;
      d_addr   = dA;
      d_wdata  = dW;
      d_strobe = dS;
   endtask

   // One clock cycle: requesters, memory responder, checks, model update.
   task automatic cycle();
      int unsigned lat;
      string       g;
      @(posedge clk);
      #1;
      if (!iPend && $urandom_range(99) < iProb) begin
         iPend = 1'b1;
         iA    = $urandom;
      end
      if (!dPend && $urandom_range(99) < dProb) begin
         dPend = 1'b1;
         dA    = $urandom;
         dW    = $urandom;
         dS    = 4'($urandom);
      end
      driveReq();
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      memData   = $urandom;
      m_data    = memData;
      if (waitCnt > 0) begin
         waitCnt--;
         if (waitCnt == 0) m_data_ok = 1'b1;
      end else if (spur) begin
         m_data_ok = 1'b1;
      end
      #1;
      if (m_valid && waitCnt == 0 && $urandom_range(99) < acceptPct) begin
         m_addr_ok = 1'b1;
         lat = $urandom_range(latMax, latMin);
         if (lat == 0) m_data_ok = 1'b1;
         else waitCnt = lat;
      end
      #1;
      chk1("m_valid", m_valid, ph == 1);
      chk1("busy", busy, ph != 0);
      chk32("m_addr", m_addr, (ph == 1) ? (ownD ? dA : iA) : 32'h0);
      chk32("m_strobe", 32'(m_strobe),
            (ph == 1 && ownD) ? 32'(dS) : 32'h0);
      chk32("m_wdata", m_wdata, (ph == 1 && ownD) ? dW : 32'h0);
      chk1("i_addr_ok", i_addr_ok, ph == 1 && !ownD && m_addr_ok);
      chk1("d_addr_ok", d_addr_ok, ph == 1 && ownD && m_addr_ok);
      chk1("i_data_ok", i_data_ok,
           !ownD && ((ph == 1 && m_addr_ok && m_data_ok) ||
                     (ph == 2 && m_data_ok)));
      chk1("d_data_ok", d_data_ok,
           ownD && ((ph == 1 && m_addr_ok && m_data_ok) ||
                    (ph == 2 && m_data_ok)));
      chk32("i_data", i_data, memData);
      chk32("d_data", d_data, memData);
      if (ph == 1 && m_addr_ok) begin
         g = ownD ? "D" : "I";
         order = {order, g};
         if (ownD) dPend = 1'b0;
         else iPend = 1'b0;
         ph = m_data_ok ? 0 : 2;
      end else if (ph == 2 && m_data_ok) begin
         ph = 0;
      end else if (ph == 0) begin
         modelDecide();
      end
   endtask

   task automatic resetDut();
      reset = 1'b1;
      iPend = 1'b0;
      dPend = 1'b0;
      driveReq();
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      waitCnt = 0;
      ph = 0;
      dRun = 0;
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   // Runs both requesters until the third data grant of a streak is in
   // its data phase, then resets asynchronously in the middle of it.
   task automatic resetInDData(input bit keepD);
      bit reached;
      resetDut();
      iProb = 100;
      dProb = 100;
      acceptPct = 100;
      latMin = 4;
      latMax = 4;
      for (int n = 0; n < 300 && !(ph == 2 && ownD && dRun == 3); n++)
         cycle();
      reached = (ph == 2 && ownD && dRun == 3);
      chk1("rst_reach_ddata", reached, 1'b1);
      #1;
      reset = 1'b1;
      m_data_ok = 1'b1;
      #1;
      chk1("rst_m_valid", m_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_d_data_ok", d_data_ok, 1'b0);
      chk32("rst_m_addr", m_addr, 32'h0);
      m_data_ok = 1'b0;
      m_addr_ok = 1'b0;
      waitCnt = 0;
      ph = 0;
      dRun = 0;
      iPend = 1'b1;
      iA = $urandom;
      dPend = keepD;
      dA = $urandom;
      dW = $urandom;
      dS = 4'($urandom);
      dProb = keepD ? 100 : 0;
      driveReq();
      #1;
      reset = 1'b0;
      modelDecide();
   endtask

   initial begin
      int start;
      reset = 1'b1;
      iPend = 1'b0;
      dPend = 1'b0;
      driveReq();
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      m_data = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk1("reset_m_valid", m_valid, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_i_addr_ok", i_addr_ok, 1'b0);
      chk1("reset_d_data_ok", d_data_ok, 1'b0);
      chk32("reset_m_addr", m_addr, 32'h0);
      chk32("reset_m_wdata", m_wdata, 32'h0);
      reset = 1'b0;

      // Single fetch
      @(posedge clk); #1;
      i_valid = 1'b1;
      i_addr = 32'hBFC00000;
      #1;
      chk1("f0_busy", busy, 1'b0);
      chk1("f0_m_valid", m_valid, 1'b0);
      @(posedge clk); #2;
      chk1("f1_m_valid", m_valid, 1'b1);
      chk32("f1_m_addr", m_addr, 32'hBFC00000);
      chk32("f1_m_strobe", 32'(m_strobe), 32'h0);
      chk1("f1_i_addr_ok", i_addr_ok, 1'b0);
      @(posedge clk); #1;
      m_addr_ok = 1'b1;
      #1;
      chk1("f2_m_valid", m_valid, 1'b1);
      chk1("f2_i_addr_ok", i_addr_ok, 1'b1);
      chk1("f2_d_addr_ok", d_addr_ok, 1'b0);
      chk1("f2_i_data_ok", i_data_ok, 1'b0);
      @(posedge clk); #1;
      m_addr_ok = 1'b0;
      i_valid = 1'b0;
      #1;
      chk1("f3_m_valid", m_valid, 1'b0);
      chk32("f3_m_addr", m_addr, 32'h0);
      chk1("f3_i_data_ok", i_data_ok, 1'b0);
      chk1("f3_busy", busy, 1'b1);
      @(posedge clk); #1;
      m_data_ok = 1'b1;
      m_data = 32'h24010001;
      #1;
      chk1("f4_i_data_ok", i_data_ok, 1'b1);
      chk32("f4_i_data", i_data, 32'h24010001);
      chk1("f4_d_data_ok", d_data_ok, 1'b0);
      @(posedge clk); #1;
      m_data_ok = 1'b0;
      #1;
      chk1("f5_busy", busy, 1'b0);
      chk1("f5_i_data_ok", i_data_ok, 1'b0);

      // Store
      @(posedge clk); #1;
      d_valid = 1'b1;
      d_addr = 32'h80000010;
      d_strobe = 4'hF;
      d_wdata = 32'hDEADBEEF;
      #1;
      chk1("s0_m_valid", m_valid, 1'b0);
      @(posedge clk); #2;
      chk1("s1_m_valid", m_valid, 1'b1);
      chk32("s1_m_addr", m_addr, 32'h80000010);
      chk32("s1_m_strobe", 32'(m_strobe), 32'hF);
      chk32("s1_m_wdata", m_wdata, 32'hDEADBEEF);
      chk1("s1_d_addr_ok", d_addr_ok, 1'b0);
      @(posedge clk); #1;
      m_addr_ok = 1'b1;
      #1;
      chk1("s2_d_addr_ok", d_addr_ok, 1'b1);
      chk32("s2_m_wdata", m_wdata, 32'hDEADBEEF);
      chk1("s2_i_addr_ok", i_addr_ok, 1'b0);
      @(posedge clk); #1;
      m_addr_ok = 1'b0;
      d_valid = 1'b0;
      #1;
      chk32("s3_m_strobe", 32'(m_strobe), 32'h0);
      chk1("s3_d_data_ok", d_data_ok, 1'b0);
      @(posedge clk); #1;
      m_data_ok = 1'b1;
      #1;
      chk1("s4_d_data_ok", d_data_ok, 1'b1);
      chk1("s4_i_data_ok", i_data_ok, 1'b0);
      @(posedge clk); #1;
      m_data_ok = 1'b0;
      #1;
      chk1("s5_d_data_ok", d_data_ok, 1'b0);
      chk1("s5_busy", busy, 1'b0);

      // Spurious memory responses in IDLE and in D_ADDR
      resetDut();
      acceptPct = 0;
      spur = 1'b1;
      repeat (3) begin
         cycle();
         chk1("spur_idle_busy", busy, 1'b0);
         chk1("spur_idle_i_data_ok", i_data_ok, 1'b0);
         chk1("spur_idle_d_data_ok", d_data_ok, 1'b0);
      end
      dProb = 100;
      cycle();
      dProb = 0;
      repeat (4) begin
         cycle();
         chk1("spur_daddr_m_valid", m_valid, 1'b1);
         chk1("spur_daddr_d_data_ok", d_data_ok, 1'b0);
      end
      spur = 1'b0;
      acceptPct = 100;
      latMin = 1;
      latMax = 1;
      repeat (4) cycle();
      chk1("spur_done_busy", busy, 1'b0);

      // Simultaneous requests, constant latency
      resetDut();
      iProb = 100;
      dProb = 100;
      order = "";
      for (int n = 0; n < 200 && order.len() < 10; n++) cycle();
      chkStr("sim_order", order.substr(0, 9), "DDDDIDDDDI");

      // Zero-latency memory, continuous fetch
      resetDut();
      iProb = 100;
      dProb = 0;
      latMin = 0;
      latMax = 0;
      start = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         chk1("zl_addr_ok", i_addr_ok, k % 2 == 1);
         chk1("zl_data_ok", i_data_ok, k % 2 == 1);
         chk1("zl_busy", busy, k % 2 == 1);
         if (i_addr_ok && i_data_ok) start++;
      end
      chk32("zl_pulses", 32'(start), 32'd10);

      // Reset in D_DATA, only fetch pending afterwards
      resetInDData(1'b0);
      cycle();
      chk1("rstA_m_valid", m_valid, 1'b1);
      chk32("rstA_m_addr", m_addr, iA);
      chk1("rstA_d_addr_ok", d_addr_ok, 1'b0);

      // Reset in D_DATA with both pending: streak restarts from zero
      resetInDData(1'b1);
      start = order.len();
      for (int n = 0; n < 200 && order.len() < start + 5; n++) cycle();
      chkStr("rstB_order", order.substr(start, start + 4), "DDDDI");

      // Randomized traffic against the model
      resetDut();
      iProb = 40;
      dProb = 50;
      acceptPct = 70;
      latMin = 0;
      latMax = 3;
      repeat (400) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
